// File: rtl/mema_loader_pkg.sv
// Shared types and derived sizes for the A-operand loader feeding the skew buffer.
package tpu_pkg;
    localparam int BITS_AB  = 8;
    localparam int DIM      = 8;
    localparam int BUS_BITS = 32;

    localparam int EPB   = BUS_BITS / BITS_AB;
    localparam int BEATS = DIM / EPB;
    localparam int DRAIN = 2 * DIM - 1;

    localparam int AW = $clog2(DIM);
    localparam int RW = $clog2(DIM + 1);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW = $clog2(DRAIN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
    typedef logic [DIM-1:0][BITS_AB-1:0] row_t;
endpackage

// File: rtl/mema_loader_if.sv
// Beat stream in, skew-buffer write/shift port and tile status out.
interface mema_loader_if;
    import tpu_pkg::*;

    logic                start;
    logic                in_valid;
    logic [BUS_BITS-1:0] in_data;
    logic                in_ready;
    row_t                Ain;
    logic [AW-1:0]       Arow;
    logic                WrEn;
    logic                en;
    logic                busy;
    logic                done;

    modport master (output start, in_valid, in_data,
                    input  in_ready, Ain, Arow, WrEn, en, busy, done);
    modport slave  (input  start, in_valid, in_data,
                    output in_ready, Ain, Arow, WrEn, en, busy, done);
endinterface

// File: rtl/mema_row_assembler.sv
// Packs accepted beats into a row buffer and presents each finished row with a write strobe.
module mema_row_assembler
    import tpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                beat_i,
    input  logic [BUS_BITS-1:0] data_i,
    output row_t                ain_o,
    output logic [AW-1:0]       arow_o,
    output logic                wren_o,
    output logic [RW-1:0]       rows_o
);
    logic [BW-1:0] beat_q, beat_d;
    logic [RW-1:0] row_q, row_d;
    row_t          asm_q, asm_d, ain_q, ain_d;
    logic [AW-1:0] arow_q, arow_d;
    logic          wren_q, wren_d;
    logic          last_beat;

    assign last_beat = beat_i && (beat_q == BW'(BEATS - 1));

    always_comb begin
        beat_d = beat_q;
        row_d  = row_q;
        asm_d  = asm_q;
        ain_d  = ain_q;
        arow_d = arow_q;
        wren_d = 1'b0;
        for (int k = 0; k < DIM; k++) begin
            if (beat_i && (beat_q == BW'(k / EPB)))
                asm_d[k] = data_i[(k % EPB)*BITS_AB +: BITS_AB];
        end
        if (clr_i) begin
            beat_d = '0;
            row_d  = '0;
        end else if (last_beat) begin
            // Row leaves through its own register so the next row can start assembling now.
            beat_d = '0;
            row_d  = row_q + 1'b1;
            ain_d  = asm_d;
            arow_d = row_q[AW-1:0];
            wren_d = 1'b1;
        end else if (beat_i) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            row_q  <= '0;
            asm_q  <= '0;
            ain_q  <= '0;
            arow_q <= '0;
            wren_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            row_q  <= row_d;
            asm_q  <= asm_d;
            ain_q  <= ain_d;
            arow_q <= arow_d;
            wren_q <= wren_d;
        end
    end

    assign ain_o  = ain_q;
    assign arow_o = arow_q;
    assign wren_o = wren_q;
    assign rows_o = row_q;
endmodule

// File: rtl/mema_loader.sv
// Tile sequencer: load DIM rows into the skew buffer, drain it, then report done.
module mema_loader
    import tpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mema_loader_if.slave bus
);
    if ((BUS_BITS % BITS_AB) != 0 || ((DIM * BITS_AB) % BUS_BITS) != 0 || DIM < 2) begin : g_bad_cfg
        $error("mema_loader: DIM*BITS_AB must be a multiple of BUS_BITS");
    end

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          clr, xfer, wren;
    logic [AW-1:0] arow;
    logic [RW-1:0] rows;

    assign bus.in_ready = (state_q == S_LOAD) && (rows < RW'(DIM));
    assign xfer         = bus.in_valid && bus.in_ready;

    mema_row_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .beat_i (xfer),
        .data_i (bus.in_data),
        .ain_o  (bus.Ain),
        .arow_o (arow),
        .wren_o (wren),
        .rows_o (rows)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_LOAD;
                clr     = 1'b1;
            end
            // Leave on the strobe of the last row so en starts right after it.
            S_LOAD: if (wren && (arow == AW'(DIM - 1))) begin
                state_d = S_DRAIN;
                drain_d = '0;
            end
            S_DRAIN: if (drain_q == DW'(DRAIN - 1)) state_d = S_DONE;
                     else drain_d = drain_q + 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign bus.Arow = arow;
    assign bus.WrEn = wren;
    assign bus.en   = (state_q == S_DRAIN);
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_mema_loader.sv
// Randomized bench for mema_loader against a row-packing and tile-timing reference model.
module tb_mema_loader;
    import tpu_pkg::*;

    localparam int NB = DIM * BEATS;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    row_t          last_ain;
    logic [AW-1:0] last_arow;

    mema_loader_if bus();
    mema_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // mode: 0 counting bytes, 1 signed extremes, 2 random. abort_rows>0 resets after that many rows.
    task automatic run_tile(input int mode, input int gap_pct, input bit poke,
                            input int abort_rows, output int done_t);
        logic [BUS_BITS-1:0] beat_w [NB];
        row_t exp_row [DIM];
        int   acc, rows_seen, lst, t;
        int   due [$];
        bit   exp_wren, exp_en, exp_done, exp_busy, exp_rdy;

        for (int n = 0; n < NB; n++)
            for (int b = 0; b < EPB; b++)
                case (mode)
                    0:       beat_w[n][b*BITS_AB +: BITS_AB] = BITS_AB'(n*EPB + b);
                    1:       beat_w[n][b*BITS_AB +: BITS_AB] = (b % 2 == 0) ? 8'h7F : 8'h80;
                    default: beat_w[n][b*BITS_AB +: BITS_AB] = BITS_AB'($urandom);
                endcase
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++)
                exp_row[r][k] = beat_w[r*BEATS + k/EPB][(k % EPB)*BITS_AB +: BITS_AB];

        acc = 0; rows_seen = 0; lst = 0; t = 0; done_t = -1;
        @(negedge clk);
        while (t < 400 && !(lst > 0 && t > lst + 19)) begin
            exp_wren = (due.size() > 0 && due[0] == t);
            if (exp_wren) void'(due.pop_front());
            exp_en   = (lst > 0 && t >= lst + 2 && t <= lst + 16);
            exp_done = (lst > 0 && t == lst + 17);
            exp_busy = (t >= 1) && !(lst > 0 && t > lst + 17);

            checks++;
            if (bus.WrEn !== exp_wren) begin
                errors++; $display("FAIL wren t=%0d got %b exp %b", t, bus.WrEn, exp_wren);
            end
            if (bus.WrEn === 1'b1 && exp_wren && rows_seen < DIM) begin
                checks++;
                if (bus.Arow !== AW'(rows_seen) || bus.Ain !== exp_row[rows_seen]) begin
                    errors++;
                    $display("FAIL row_data t=%0d got arow=%0d ain=%h exp arow=%0d ain=%h",
                             t, bus.Arow, bus.Ain, rows_seen, exp_row[rows_seen]);
                end
                if (mode == 1 && rows_seen == 0) begin
                    checks++;
                    if ($signed(bus.Ain[0]) != 127 || $signed(bus.Ain[1]) != -128) begin
                        errors++;
                        $display("FAIL signed_ext got %0d,%0d exp 127,-128",
                                 $signed(bus.Ain[0]), $signed(bus.Ain[1]));
                    end
                end
                last_ain  = exp_row[rows_seen];
                last_arow = AW'(rows_seen);
                rows_seen++;
            end else if (bus.WrEn === 1'b0) begin
                checks++;
                if (bus.Ain !== last_ain || bus.Arow !== last_arow) begin
                    errors++;
                    $display("FAIL hold t=%0d got arow=%0d ain=%h exp arow=%0d ain=%h",
                             t, bus.Arow, bus.Ain, last_arow, last_ain);
                end
            end
            checks++;
            if (bus.en !== exp_en || bus.done !== exp_done || bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL ctrl t=%0d got en=%b done=%b busy=%b exp en=%b done=%b busy=%b",
                         t, bus.en, bus.done, bus.busy, exp_en, exp_done, exp_busy);
            end
            checks++;
            if (bus.WrEn === 1'b1 && bus.en === 1'b1) begin
                errors++; $display("FAIL overlap t=%0d got WrEn=1 en=1 exp never both", t);
            end
            if (bus.done === 1'b1) done_t = t;

            if (abort_rows > 0 && rows_seen == abort_rows) begin
                rst = 1'b1;
                #1;
                checks++;
                if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.WrEn !== 1'b0 ||
                    bus.en !== 1'b0 || bus.done !== 1'b0 || bus.Ain !== '0 || bus.Arow !== '0) begin
                    errors++;
                    $display("FAIL midreset got busy=%b rdy=%b wren=%b en=%b done=%b ain=%h arow=%0d exp all 0",
                             bus.busy, bus.in_ready, bus.WrEn, bus.en, bus.done, bus.Ain, bus.Arow);
                end
                bus.start = 1'b0; bus.in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                last_ain = '0; last_arow = '0;
                return;
            end

            bus.start = (t == 0) || (poke && (t == 5 || (lst > 0 && t == lst + 5)));
            if (acc < NB) begin
                bus.in_valid = (t == 0) ? poke : (int'($urandom_range(99)) >= gap_pct);
                bus.in_data  = beat_w[acc];
            end else begin
                bus.in_valid = poke;
                bus.in_data  = BUS_BITS'($urandom);
            end
            #1;
            exp_rdy = (t >= 1) && (acc < NB);
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++; $display("FAIL in_ready t=%0d got %b exp %b", t, bus.in_ready, exp_rdy);
            end
            if (bus.in_valid && bus.in_ready === 1'b1 && acc < NB) begin
                acc++;
                if (acc % BEATS == 0) due.push_back(t + 1);
                if (acc == NB) lst = t;
            end
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (done_t < 0 || rows_seen != DIM) begin
            errors++; $display("FAIL tile_end got done_t=%0d rows=%0d exp done seen, rows=%0d",
                               done_t, rows_seen, DIM);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = BUS_BITS'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.Ain !== '0 || bus.Arow !== '0 || bus.WrEn !== 1'b0 ||
            bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b ain=%h arow=%0d wren=%b en=%b busy=%b done=%b exp all 0",
                     bus.in_ready, bus.Ain, bus.Arow, bus.WrEn, bus.en, bus.busy, bus.done);
        end
        bus.start = 1'b0; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL idle_ready got rdy=%b busy=%b exp 0,0", bus.in_ready, bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        last_ain = '0; last_arow = '0;
    endtask

    task automatic test_full_tile();
        int dt;
        run_tile(0, 0, 1'b0, 0, dt);
        checks++;
        if (dt != 1 + 2*DIM + 1 + DRAIN) begin
            errors++; $display("FAIL tile_latency got %0d exp %0d", dt, 1 + 2*DIM + 1 + DRAIN);
        end
    endtask

    task automatic test_gaps();
        int dt;
        run_tile(0, 30, 1'b0, 0, dt);
        run_tile(2, 30, 1'b0, 0, dt);
    endtask

    task automatic test_protocol_guards();
        int dt;
        run_tile(2, 20, 1'b1, 0, dt);
    endtask

    task automatic test_reset_midtile();
        int dt;
        run_tile(2, 10, 1'b0, 3, dt);
        run_tile(0, 0, 1'b0, 0, dt);
    endtask

    task automatic test_signed_extremes();
        int dt;
        run_tile(1, 0, 1'b0, 0, dt);
        checks++;
        if (dt != 1 + 2*DIM + 1 + DRAIN) begin
            errors++; $display("FAIL ext_latency got %0d exp %0d", dt, 1 + 2*DIM + 1 + DRAIN);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        last_ain = '0; last_arow = '0;
        rst = 1'b1;
        test_reset();
        test_full_tile();
        test_gaps();
        test_protocol_guards();
        test_reset_midtile();
        test_signed_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
